// File: rtl/insn_fetch.sv
// Instruction fetch front end: sequential word requests, 2-entry {pc, insn} buffer,
// redirect flush of in-flight responses. Define MIG_FETCH_TRACE_EN for a text trace.
module insn_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-3:0] redirect_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  fetch_en,
    output logic [ADDR_WIDTH-3:0] fetch_pc,
    output logic [31:0]           insn
);

    localparam int         AW       = ADDR_WIDTH - 2;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [1:0]    out_q, out_d;
    logic [1:0]    drop_q, drop_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          head_q, head_d;
    logic [AW-1:0] pc_mem_q [0:1];
    logic [AW-1:0] pc_mem_d [0:1];
    logic [31:0]   data_mem_q [0:1];
    logic [31:0]   data_mem_d [0:1];

    logic          pop_s;
    logic          push_s;
    logic          accept_s;
    logic          wr_idx_s;
    logic [2:0]    level_s;
    logic [1:0]    drop_next_s;
    logic [AW-1:0] oldest_pc_s;

    // A slot freed by this cycle's pop may be reserved immediately, giving one insn per cycle.
    assign pop_s         = (cnt_q != 2'd0) && !stall && !redirect_valid;
    assign level_s       = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop_s};
    assign mem_req_valid = (state_q == ST_RUN) && !redirect_valid && (level_s < 3'd2);
    assign accept_s      = mem_req_valid && mem_req_ready;
    assign push_s        = (state_q == ST_RUN) && mem_rsp_valid && !redirect_valid;
    assign wr_idx_s      = head_q ^ cnt_q[0];
    // Requests since the last redirect are consecutive, so the oldest one trails req_pc.
    assign oldest_pc_s   = req_pc_q - AW'(out_q);
    assign drop_next_s   = out_q + drop_q - {1'b0, mem_rsp_valid};

    assign mem_req_addr  = req_pc_q;
    assign fetch_en      = pop_s;
    assign fetch_pc      = pc_mem_q[head_q];
    assign insn          = data_mem_q[head_q];

    // Next-state logic for the sequencer, request counter and buffer.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;
        if (redirect_valid) begin
            req_pc_d = redirect_pc;
            out_d    = 2'd0;
            cnt_d    = 2'd0;
            drop_d   = drop_next_s;
            if (drop_next_s != 2'd0) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        req_pc_d = req_pc_q + {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        req_pc_d = req_pc_q;
                    end
                    if (push_s) begin
                        pc_mem_d[wr_idx_s]   = oldest_pc_s;
                        data_mem_d[wr_idx_s] = mem_rsp_data;
                    end else begin
                        pc_mem_d = pc_mem_q;
                    end
                    out_d  = out_q + {1'b0, accept_s} - {1'b0, push_s};
                    cnt_d  = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
                    head_d = head_q ^ pop_s;
                end
                ST_FLUSH: begin
                    if (mem_rsp_valid) begin
                        drop_d = drop_q - 2'd1;
                        if (drop_q == 2'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        drop_d = drop_q;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            req_pc_q   <= BOOT_ADDR[ADDR_WIDTH-1:2];
            out_q      <= 2'd0;
            drop_q     <= 2'd0;
            cnt_q      <= 2'd0;
            head_q     <= 1'b0;
            pc_mem_q   <= '{default: '0};
            data_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            pc_mem_q   <= pc_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

`ifdef MIG_FETCH_TRACE_EN
    // Text trace of delivered instructions and redirects.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            $display("%0t Fetch: pc:%h, data:%h", $time, {fetch_pc, 2'b00}, insn);
        end
        if (rst && redirect_valid) begin
            $display("%0t Fetch: redirect pc:%h", $time, {redirect_pc, 2'b00});
        end
    end
`else
    // Trace disabled: no output, identical cycle behaviour.
`endif

endmodule
